systolic_feed_scheduler: RTL and testbench

//  Sequences one NxN matrix-multiply pass on the systolic array. Pops operands from the N row
//  (A) FIFOs and N column (B) FIFOs in skewed order: lane i starts i cycles after lane 0. Gates

---
 rtl/systolic_feed_scheduler.sv | 138 +++++++++++++
 tb/tb_systolic_feed_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_scheduler.sv
// Skewed operand-feed sequencer for an NxN systolic array: CLEAR, FEED (with underflow stall), DRAIN, DONE.
// Optional stall performance counter enabled by defining SCHED_PERF_EN.
module systolic_feed_scheduler #(
  parameter int N     = 4,
  parameter int K     = 4,
  parameter int CNT_W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a_empty,
  input  logic [N-1:0] b_empty,
  output logic [N-1:0] a_pop,
  output logic [N-1:0] b_pop,
  output logic [N-1:0] a_lane_vld,
  output logic [N-1:0] b_lane_vld,
  output logic         array_en,
  output logic         pe_clear,
  output logic         busy,
  output logic         done
`ifdef SCHED_PERF_EN
  ,
  output logic [15:0]  stall_cnt
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(K + N - 2);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(N - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] t_q, t_d;
  logic [N-1:0]     lane_act;
  logic             stall;

  // Lane gi is live for gi <= t < gi+K; the subtraction wraps large when t < gi.
  for (genvar gi = 0; gi < N; gi++) begin : g_lane
    assign lane_act[gi] = (({1'b0, t_q} - (CNT_W+1)'(gi)) < (CNT_W+1)'(K));
  end

  assign stall = |(lane_act & (a_empty | b_empty));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      t_q     <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        state_d = S_FEED;
        t_d     = '0;
      end
      S_FEED: begin
        if (!stall) begin
          if (t_q == FEED_LAST) begin
            state_d = S_DRAIN;
            t_d     = '0;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (t_q == DRAIN_LAST) begin
          state_d = S_DONE;
          t_d     = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    a_pop      = '0;
    b_pop      = '0;
    a_lane_vld = '0;
    b_lane_vld = '0;
    array_en   = 1'b0;
    pe_clear   = 1'b0;
    done       = 1'b0;
    busy       = (state_q != S_IDLE);
    case (state_q)
      S_CLEAR: pe_clear = 1'b1;
      S_FEED: begin
        if (!stall) begin
          a_pop      = lane_act;
          b_pop      = lane_act;
          a_lane_vld = lane_act;
          b_lane_vld = lane_act;
          array_en   = 1'b1;
        end
      end
      S_DRAIN: array_en = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

`ifdef SCHED_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (state_q == S_CLEAR) begin
      stall_cnt_d = '0;
    end else if ((state_q == S_FEED) && stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_systolic_feed_scheduler.sv
// Scoreboard bench for systolic_feed_scheduler with FIFO-bank and PE-grid models around the DUT.
module tb_systolic_feed_scheduler;
  localparam int N = 4;
  localparam int K = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [N-1:0] a_empty, b_empty, a_pop, b_pop, a_lane_vld, b_lane_vld;
  logic         array_en, pe_clear, busy, done;
`ifdef SCHED_PERF_EN
  logic [15:0]  stall_cnt;
`endif

  systolic_feed_scheduler #(.N(N), .K(K), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .a_empty(a_empty), .b_empty(b_empty),
    .a_pop(a_pop), .b_pop(b_pop),
    .a_lane_vld(a_lane_vld), .b_lane_vld(b_lane_vld),
    .array_en(array_en), .pe_clear(pe_clear), .busy(busy), .done(done)
`ifdef SCHED_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(string tag, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Operand FIFO bank model: each lane holds fill_words words, popped by the DUT.
  int           a_mem[N][8];
  int           b_mem[N][8];
  int           a_rd[N];
  int           b_rd[N];
  int           fill_words = 4;
  logic         fill_req = 1'b0;
  logic [N-1:0] a_force = '0;
  logic [N-1:0] b_force = '0;

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (fill_req) begin
        a_rd[i] <= 0;
        b_rd[i] <= 0;
      end else begin
        if (a_pop[i]) a_rd[i] <= a_rd[i] + 1;
        if (b_pop[i]) b_rd[i] <= b_rd[i] + 1;
      end
    end
  end

  always_comb begin
    a_empty = '0;
    b_empty = '0;
    for (int i = 0; i < N; i++) begin
      a_empty[i] = (a_rd[i] >= fill_words) || a_force[i];
      b_empty[i] = (b_rd[i] >= fill_words) || b_force[i];
    end
  end

  // PE grid model: A flows right, B flows down, each PE accumulates the product of its inputs.
  int in_a[N];
  int in_b[N];
  int a_sh[N][N];
  int b_sh[N][N];
  int acc[N][N];
  int av, bv;

  always_comb begin
    in_a = '{default: 0};
    in_b = '{default: 0};
    for (int i = 0; i < N; i++) begin
      in_a[i] = (a_lane_vld[i] && a_rd[i] < 8) ? a_mem[i][a_rd[i]] : 0;
      in_b[i] = (b_lane_vld[i] && b_rd[i] < 8) ? b_mem[i][b_rd[i]] : 0;
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (rst) begin
          a_sh[i][j] <= 0;
          b_sh[i][j] <= 0;
          acc[i][j]  <= 0;
        end else if (pe_clear) begin
          acc[i][j] <= 0;
        end else if (array_en) begin
          av = (j == 0) ? in_a[i] : a_sh[i][(j == 0) ? 0 : j - 1];
          bv = (i == 0) ? in_b[j] : b_sh[(i == 0) ? 0 : i - 1][j];
          a_sh[i][j] <= av;
          b_sh[i][j] <= bv;
          acc[i][j]  <= acc[i][j] + av * bv;
        end
      end
    end
  end

  typedef struct {
    int         cyc;
    logic [3:0] pop;
    logic       en;
    logic       clr;
    logic       bsy;
    logic       dn;
  } exp_t;

  exp_t cyc_q[$];
  int   done_q[$];
  exp_t mon_e;

  always @(negedge clk) begin
    if (cyc_q.size() > 0 && cyc_q[0].cyc == cyc) begin
      mon_e = cyc_q.pop_front();
      check_eq("a_pop",      int'(a_pop),      int'(mon_e.pop));
      check_eq("b_pop",      int'(b_pop),      int'(mon_e.pop));
      check_eq("a_lane_vld", int'(a_lane_vld), int'(mon_e.pop));
      check_eq("b_lane_vld", int'(b_lane_vld), int'(mon_e.pop));
      check_eq("array_en",   int'(array_en),   int'(mon_e.en));
      check_eq("pe_clear",   int'(pe_clear),   int'(mon_e.clr));
      check_eq("busy",       int'(busy),       int'(mon_e.bsy));
      check_eq("done",       int'(done),       int'(mon_e.dn));
    end
    if (done) begin
      if (done_q.size() == 0) check_eq("unexpected_done", cyc, -1);
      else                    check_eq("done_cycle", cyc, done_q.pop_front());
    end
    if (busy) begin
      check_eq("pop_on_empty_a", int'(a_pop & a_empty), 0);
      check_eq("pop_on_empty_b", int'(b_pop & b_empty), 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(int c, logic [3:0] p, logic en, logic clr, logic bsy, logic dn);
    exp_t e;
    e.cyc = c; e.pop = p; e.en = en; e.clr = clr; e.bsy = bsy; e.dn = dn;
    cyc_q.push_back(e);
  endtask

  // Expected cycle-by-cycle response of a stall-free pass started in cycle c0.
  task automatic push_clean_pass(int c0);
    logic [3:0] p;
    for (int k = 1; k <= 14; k++) begin
      p = '0;
      if (k >= 2 && k <= 8) begin
        for (int i = 0; i < N; i++) p[i] = (i <= k - 2) && (k - 2 < i + K);
      end
      push_exp(c0 + k, p, (k >= 2 && k <= 12), (k == 1), (k <= 13), (k == 13));
    end
  endtask

  task automatic fill(int w);
    fill_words = w;
    fill_req   = 1'b1;
    step();
    fill_req   = 1'b0;
  endtask

  task automatic run_wait(int budget);
    int n;
    n = 0;
    while ((done_q.size() > 0 || cyc_q.size() > 0 || busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) begin
      check_eq("wait_timeout", n, -1);
      done_q.delete();
      cyc_q.delete();
    end
  endtask

  int c0;

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < 8; k++) begin
        a_mem[i][k] = 0;
        b_mem[i][k] = 0;
      end
    end
    step(); step(); step();
    check_eq("rst_busy",     int'(busy),     0);
    check_eq("rst_done",     int'(done),     0);
    check_eq("rst_a_pop",    int'(a_pop),    0);
    check_eq("rst_array_en", int'(array_en), 0);
    check_eq("rst_pe_clear", int'(pe_clear), 0);
    rst = 1'b0;
    step();

    // Clean pass
    fill(4);
    c0 = cyc;
    push_clean_pass(c0);
    done_q.push_back(c0 + 13);
    start = 1'b1; step(); start = 1'b0;
    run_wait(60);
    $display("txn clean_pass start=%0d", c0);

    // b_empty[2] forced while t=2 for three cycles
    fill(4);
    c0 = cyc;
    done_q.push_back(c0 + 16);
    push_exp(c0 + 4, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(c0 + 5, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(c0 + 6, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(c0 + 7, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    while (cyc < c0 + 4) step();
    b_force[2] = 1'b1;
    while (cyc < c0 + 7) step();
    b_force = '0;
    run_wait(60);
`ifdef SCHED_PERF_EN
    check_eq("stall_cnt_b2", int'(stall_cnt), 3);
`endif
    $display("txn stall_b2 start=%0d", c0);

    // a_empty[3] ignored while lane 3 inactive, stalls once it goes live
    fill(4);
    c0 = cyc;
    done_q.push_back(c0 + 15);
    push_exp(c0 + 4, 4'b0111, 1'b1, 1'b0, 1'b1, 1'b0);
    push_exp(c0 + 5, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(c0 + 6, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(c0 + 7, 4'b1111, 1'b1, 1'b0, 1'b1, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    a_force[3] = 1'b1;
    while (cyc < c0 + 7) step();
    a_force = '0;
    run_wait(60);
`ifdef SCHED_PERF_EN
    check_eq("stall_cnt_a3", int'(stall_cnt), 2);
`endif
    $display("txn inactive_lane_empty start=%0d", c0);

    // Reset mid-pass at t=4, then a fresh pass
    fill(4);
    c0 = cyc;
    start = 1'b1; step(); start = 1'b0;
    while (cyc < c0 + 6) step();
    rst = 1'b1;
    push_exp(c0 + 7, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) step();
    check_eq("abort_no_done_pending", cyc_q.size(), 0);
    fill(4);
    c0 = cyc;
    push_clean_pass(c0);
    done_q.push_back(c0 + 13);
    start = 1'b1; step(); start = 1'b0;
    run_wait(60);
    $display("txn reset_abort_restart start=%0d", c0);

    // start held high: two back-to-back passes
    fill(8);
    c0 = cyc;
    done_q.push_back(c0 + 13);
    done_q.push_back(c0 + 27);
    push_exp(c0 + 14, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
    push_exp(c0 + 15, 4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    while (cyc < c0 + 27) step();
    start = 1'b0;
    run_wait(60);
    $display("txn back_to_back start=%0d", c0);

    // End-to-end: A = identity, B = 1..16 row-major
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < K; k++) begin
        a_mem[i][k] = (i == k) ? 1 : 0;
        b_mem[i][k] = k * N + i + 1;
      end
    end
    fill(4);
    c0 = cyc;
    done_q.push_back(c0 + 13);
    start = 1'b1; step(); start = 1'b0;
    run_wait(60);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        check_eq($sformatf("acc[%0d][%0d]", i, j), acc[i][j], i * N + j + 1);
      end
    end
    $display("txn end_to_end start=%0d", c0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
